wb_host_slave_p: RTL

WB_HOST_SLAVE_P -- requirements
Module: wb_host_slave_p

---
 rtl/wb_host_pkg.sv | 33 +++
 rtl/wb_tmo_cnt.sv | 44 ++++
 rtl/wb_host_slave_p.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/wb_host_pkg.sv
// ----------------------------------------------------------------------------
// wb_host_pkg
//   Shared definitions for the Wishbone host slave bridge:
//   - state_t       : bridge FSM state encoding
//   - DEF_*         : default bus geometry and execute/FIFO window addresses
//   - tmo_width()   : width of the WAIT timeout counter for a given TMO
// ----------------------------------------------------------------------------
package wb_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_EXEC  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int DEF_DW          = 128;
  localparam int DEF_AW          = 5;
  localparam int DEF_NREG        = 16;
  localparam int DEF_CMD_ADR     = 16;
  localparam int DEF_FIFO_WR_ADR = 17;
  localparam int DEF_FIFO_RD_ADR = 18;
  localparam int DEF_DAT_ADR     = 19;
  localparam int DEF_TMO         = 1024;

  // Counter must hold TMO-1; a single bit is the floor for tiny timeouts.
  function automatic int tmo_width(input int tmo);
    return (tmo <= 2) ? 1 : $clog2(tmo);
  endfunction

endpackage

// File: rtl/wb_tmo_cnt.sv
// ----------------------------------------------------------------------------
// wb_tmo_cnt
//   WAIT-state timeout counter. Counts up while en is high, saturating at
//   TMO-1; clr returns it to zero and has priority over en.
//
//   Ports
//     clock  in   rising-edge clock
//     reset  in   asynchronous active-high reset
//     clr    in   synchronous clear
//     en     in   count enable
//     tc     out  terminal count: counter currently equals TMO-1
// ----------------------------------------------------------------------------
module wb_tmo_cnt
  import wb_host_pkg::*;
#(
  parameter int TMO = DEF_TMO
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int             CW   = tmo_width(TMO);
  localparam logic [CW-1:0]  LAST = CW'(TMO - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/wb_host_slave_p.sv
// ----------------------------------------------------------------------------
// wb_host_slave_p
//   Wishbone slave that bridges master accesses onto a simple host strobe
//   interface. Plain reads/writes complete in one cycle; writes to the
//   command or data execute addresses launch a host operation and hold the
//   bus until the matching completion strobe arrives or the WAIT timeout
//   expires.
//
//   Ports
//     clock, reset                     clock / async active-high reset
//     cyc_i, stb_i, we_i               Wishbone cycle, strobe, write enable
//     adr_i [AW], dat_i [DW]           master address / write data
//     dat_o [DW], ack_o, err_o         read data, acknowledge, error
//     host_data_i [DW]                 host read data
//     cmd_done_i, data_done_i          host completion strobes
//     host_data_o [DW], adr_o [AW]     host write data / address
//     reg_read_en, reg_write_en,
//     fifo_read_en, fifo_write_en,
//     new_command, new_data            single-cycle host strobes
// ----------------------------------------------------------------------------
module wb_host_slave_p
  import wb_host_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int NREG        = DEF_NREG,
  parameter int CMD_ADR     = DEF_CMD_ADR,
  parameter int FIFO_WR_ADR = DEF_FIFO_WR_ADR,
  parameter int FIFO_RD_ADR = DEF_FIFO_RD_ADR,
  parameter int DAT_ADR     = DEF_DAT_ADR,
  parameter int TMO         = DEF_TMO
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  output logic          ack_o,
  output logic          err_o,
  input  logic [DW-1:0] host_data_i,
  input  logic          cmd_done_i,
  input  logic          data_done_i,
  output logic [DW-1:0] host_data_o,
  output logic [AW-1:0] adr_o,
  output logic          reg_read_en,
  output logic          reg_write_en,
  output logic          fifo_read_en,
  output logic          fifo_write_en,
  output logic          new_command,
  output logic          new_data
);

  localparam logic [AW-1:0] CMD_A  = AW'(CMD_ADR);
  localparam logic [AW-1:0] DAT_A  = AW'(DAT_ADR);
  localparam logic [AW-1:0] FWR_A  = AW'(FIFO_WR_ADR);
  localparam logic [AW-1:0] FRD_A  = AW'(FIFO_RD_ADR);

  state_t        state;
  logic [AW-1:0] adr_q;      // address captured at acceptance
  logic          tmo_tc;
  logic          done_match;

  // Register window compare done in 32-bit so NREG == 2**AW still works.
  function automatic logic in_regs(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  // Only the completion strobe belonging to the launched operation counts.
  assign done_match = (adr_q == CMD_A) ? cmd_done_i : data_done_i;

  wb_tmo_cnt #(
    .TMO (TMO)
  ) u_tmo (
    .clock (clock),
    .reset (reset),
    .clr   (state == S_EXEC),
    .en    (state == S_WAIT),
    .tc    (tmo_tc)
  );

  // Read data is a direct path from the host during the READ cycle so the
  // host can answer the reg/fifo read strobe in that same cycle.
  assign dat_o = (state == S_READ) ? host_data_i : '0;

  // All strobes/ack/err are registered: they are computed on the edge that
  // enters the state in which they must be visible, and cleared by default.
  // NOTE: every register, including the captured address and the host-side
  // outputs, is asynchronously reset so no stale transaction survives reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      adr_q         <= '0;
      ack_o         <= 1'b0;
      err_o         <= 1'b0;
      reg_read_en   <= 1'b0;
      reg_write_en  <= 1'b0;
      fifo_read_en  <= 1'b0;
      fifo_write_en <= 1'b0;
      new_command   <= 1'b0;
      new_data      <= 1'b0;
      adr_o         <= '0;
      host_data_o   <= '0;
    end else begin
      ack_o         <= 1'b0;
      err_o         <= 1'b0;
      reg_read_en   <= 1'b0;
      reg_write_en  <= 1'b0;
      fifo_read_en  <= 1'b0;
      fifo_write_en <= 1'b0;
      new_command   <= 1'b0;
      new_data      <= 1'b0;
      adr_o         <= '0;
      host_data_o   <= '0;

      unique case (state)
        S_IDLE: begin
          if (cyc_i && stb_i) begin
            adr_q <= adr_i;
            if (!we_i) begin
              state <= S_READ;
              ack_o <= 1'b1;
              if (in_regs(adr_i)) begin
                reg_read_en <= 1'b1;
                adr_o       <= adr_i;
              end else if (adr_i == FRD_A) begin
                fifo_read_en <= 1'b1;
                adr_o        <= adr_i;
              end else begin
                err_o <= 1'b1;
              end
            end else if ((adr_i == CMD_A) || (adr_i == DAT_A)) begin
              state       <= S_EXEC;
              new_command <= (adr_i == CMD_A);
              new_data    <= (adr_i == DAT_A);
            end else begin
              state       <= S_WRITE;
              ack_o       <= 1'b1;
              host_data_o <= dat_i;
              if (in_regs(adr_i)) begin
                reg_write_en <= 1'b1;
                adr_o        <= adr_i;
              end else if (adr_i == FWR_A) begin
                fifo_write_en <= 1'b1;
                adr_o         <= adr_i;
              end else begin
                err_o <= 1'b1;
              end
            end
          end
        end

        S_READ, S_WRITE, S_DONE: begin
          state <= S_IDLE;
        end

        S_EXEC: begin
          // Counter is cleared this cycle; WAIT starts counting from zero.
          if (!cyc_i) begin
            state <= S_IDLE;
          end else if (done_match) begin
            state <= S_DONE;
            ack_o <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A matching done beats the timeout when both land in one cycle.
          if (!cyc_i) begin
            state <= S_IDLE;
          end else if (done_match) begin
            state <= S_DONE;
            ack_o <= 1'b1;
          end else if (tmo_tc) begin
            state <= S_DONE;
            ack_o <= 1'b1;
            err_o <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
